// File: rtl/chicken_board_pkg.sv
// Shared constants for the chicken race board and the tile-order randomiser,
// plus the board FSM state encoding.
package chicken_board_pkg;
    localparam int N_EDGE   = 24;
    localparam int N_CENTER = 12;
    localparam int TILE_W   = 4;
    localparam int POS_W    = 5;
    localparam int PLY_W    = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TURN   = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;
    localparam logic [1:0] S_WIN    = 2'd3;
endpackage

// File: rtl/chicken_board_ring_target.sv
// Next free edge position ahead of a chicken, skipping occupied tiles, with wrap.
module ring_target
    import chicken_board_pkg::*;
#(
    parameter int N_PLAYERS = 2
) (
    input  logic [POS_W-1:0]  cur_pos_i,
    input  logic [N_EDGE-1:0] occ_i,
    output logic [POS_W-1:0]  tgt_o,
    output logic [POS_W-1:0]  step_o
);
    always_comb begin
        logic [POS_W-1:0] pc;
        logic             found;
        tgt_o  = '0;
        step_o = '0;
        found  = 1'b0;
        pc     = cur_pos_i;
        // Other chickens number N_PLAYERS-1, so a free slot exists within N_PLAYERS steps.
        for (int k = 1; k <= N_PLAYERS; k++) begin
            pc = (pc == POS_W'(N_EDGE - 1)) ? '0 : pc + POS_W'(1);
            if (!found && !occ_i[pc]) begin
                tgt_o  = pc;
                step_o = POS_W'(k);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/chicken_board.sv
// Chicken race game-board engine: captures tile orders, runs flips, moves
// chickens around the edge ring and detects the winner.
module chicken_board
    import chicken_board_pkg::*;
#(
    parameter int N_PLAYERS = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic [N_EDGE*TILE_W-1:0]     edge_order_i,
    input  logic [N_CENTER*TILE_W-1:0]   center_order_i,
    input  logic                         flip_valid_i,
    input  logic [3:0]                   flip_idx_i,
    output logic                         flip_ready_o,
    output logic                         flip_err_o,
    output logic [PLY_W-1:0]             cur_player_o,
    output logic [N_PLAYERS*POS_W-1:0]   player_pos_o,
    output logic [N_CENTER-1:0]          center_revealed_o,
    output logic                         result_valid_o,
    output logic                         result_match_o,
    output logic                         winner_valid_o,
    output logic [PLY_W-1:0]             winner_o
);
    logic [1:0]                          state_q, state_d;
    logic [N_EDGE-1:0][TILE_W-1:0]       edge_q, edge_d;
    logic [N_CENTER-1:0][TILE_W-1:0]     center_q, center_d;
    logic [N_PLAYERS-1:0][POS_W-1:0]     pos_q, pos_d, dist_q, dist_d;
    logic [N_CENTER-1:0]                 rev_q, rev_d;
    logic [PLY_W-1:0]                    cur_q, cur_d, winner_q, winner_d;
    logic                                flip_err_q, flip_err_d, match_q, match_d;
    logic [POS_W-1:0]                    tgt_q, tgt_d, step_q, step_d;

    logic [POS_W-1:0]  cur_pos, cur_dist, tgt, step, dist_new;
    logic [N_EDGE-1:0] occ;
    logic [POS_W:0]    dsum;
    logic              flip_ok;

    always_comb begin
        cur_pos  = '0;
        cur_dist = '0;
        occ      = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (cur_q == PLY_W'(i)) begin
                cur_pos  = pos_q[i];
                cur_dist = dist_q[i];
            end else begin
                occ[pos_q[i]] = 1'b1;
            end
        end
        dsum     = {1'b0, cur_dist} + {1'b0, step_q};
        dist_new = dsum[POS_W] ? '1 : dsum[POS_W-1:0];
        flip_ok  = (int'(flip_idx_i) < N_CENTER) ? !rev_q[flip_idx_i] : 1'b0;
    end

    ring_target #(.N_PLAYERS(N_PLAYERS)) u_ring (
        .cur_pos_i (cur_pos),
        .occ_i     (occ),
        .tgt_o     (tgt),
        .step_o    (step)
    );

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        center_d   = center_q;
        pos_d      = pos_q;
        dist_d     = dist_q;
        rev_d      = rev_q;
        cur_d      = cur_q;
        winner_d   = winner_q;
        match_d    = match_q;
        tgt_d      = tgt_q;
        step_d     = step_q;
        flip_err_d = 1'b0;
        case (state_q)
            S_TURN: if (flip_valid_i) begin
                if (!flip_ok) begin
                    flip_err_d = 1'b1;
                end else begin
                    // Outcome is resolved here so RESULT only applies it.
                    rev_d[flip_idx_i] = 1'b1;
                    match_d = (center_q[flip_idx_i] == edge_q[tgt]);
                    tgt_d   = tgt;
                    step_d  = step;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                state_d = S_TURN;
                if (match_q) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (cur_q == PLY_W'(i)) begin
                            pos_d[i]  = tgt_q;
                            dist_d[i] = dist_new;
                        end
                    end
                    if (int'(dsum) >= N_EDGE) begin
                        winner_d = cur_q;
                        state_d  = S_WIN;
                    end else if (&rev_q) begin
                        rev_d = '0;
                    end
                end else begin
                    rev_d = '0;
                    cur_d = (int'(cur_q) == N_PLAYERS - 1) ? '0 : cur_q + PLY_W'(1);
                end
            end
            default: ;
        endcase
        if (load_i) begin
            edge_d     = edge_order_i;
            center_d   = center_order_i;
            for (int i = 0; i < N_PLAYERS; i++) begin
                pos_d[i]  = POS_W'(i * N_EDGE / N_PLAYERS);
                dist_d[i] = '0;
            end
            rev_d      = '0;
            cur_d      = '0;
            winner_d   = '0;
            match_d    = 1'b0;
            flip_err_d = 1'b0;
            state_d    = S_TURN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            edge_q     <= '0;
            center_q   <= '0;
            pos_q      <= '0;
            dist_q     <= '0;
            rev_q      <= '0;
            cur_q      <= '0;
            winner_q   <= '0;
            match_q    <= 1'b0;
            tgt_q      <= '0;
            step_q     <= '0;
            flip_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            center_q   <= center_d;
            pos_q      <= pos_d;
            dist_q     <= dist_d;
            rev_q      <= rev_d;
            cur_q      <= cur_d;
            winner_q   <= winner_d;
            match_q    <= match_d;
            tgt_q      <= tgt_d;
            step_q     <= step_d;
            flip_err_q <= flip_err_d;
        end
    end

    assign flip_ready_o      = (state_q == S_TURN);
    assign flip_err_o        = flip_err_q;
    assign cur_player_o      = cur_q;
    assign player_pos_o      = pos_q;
    assign center_revealed_o = rev_q;
    assign result_valid_o    = (state_q == S_RESULT);
    assign result_match_o    = match_q & (state_q == S_RESULT);
    assign winner_valid_o    = (state_q == S_WIN);
    assign winner_o          = winner_q;
endmodule

// File: tb/tb_chicken_board.sv
// Randomised game play against a turn-level model of the chicken race rules.
module tb_chicken_board;
    import chicken_board_pkg::*;
    localparam int NP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst, load, flip_valid;
    logic [N_EDGE*TILE_W-1:0]    edge_order;
    logic [N_CENTER*TILE_W-1:0]  center_order;
    logic [3:0]                  flip_idx;
    logic                        flip_ready, flip_err, result_valid, result_match, winner_valid;
    logic [1:0]                  cur_player, winner;
    logic [NP*5-1:0]             player_pos;
    logic [N_CENTER-1:0]         center_revealed;

    chicken_board #(.N_PLAYERS(NP)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load),
        .edge_order_i(edge_order), .center_order_i(center_order),
        .flip_valid_i(flip_valid), .flip_idx_i(flip_idx),
        .flip_ready_o(flip_ready), .flip_err_o(flip_err),
        .cur_player_o(cur_player), .player_pos_o(player_pos),
        .center_revealed_o(center_revealed),
        .result_valid_o(result_valid), .result_match_o(result_match),
        .winner_valid_o(winner_valid), .winner_o(winner)
    );

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: mode 0 = idle, 1 = waiting for a flip, 2 = game won.
    int m_edge[N_EDGE], m_center[N_CENTER], m_pos[NP], m_dist[NP];
    int m_cur, m_mode, m_winner;
    bit m_rev[N_CENTER];

    function automatic logic [N_CENTER-1:0] rev_vec();
        logic [N_CENTER-1:0] v;
        for (int k = 0; k < N_CENTER; k++) v[k] = m_rev[k];
        return v;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".ready"}, flip_ready, m_mode == 1);
        chk({tag, ".cur"}, cur_player, m_cur);
        for (int i = 0; i < NP; i++)
            chk($sformatf("%s.pos%0d", tag, i), player_pos[i*5 +: 5], m_pos[i]);
        chk({tag, ".rev"}, center_revealed, rev_vec());
        chk({tag, ".wv"}, winner_valid, m_mode == 2);
        if (m_mode == 2) chk({tag, ".winner"}, winner, m_winner);
    endtask

    task automatic do_load(input bit with_flip);
        @(negedge clk);
        for (int k = 0; k < N_EDGE; k++) edge_order[k*4 +: 4] = 4'(m_edge[k]);
        for (int k = 0; k < N_CENTER; k++) center_order[k*4 +: 4] = 4'(m_center[k]);
        load = 1'b1;
        flip_valid = with_flip;
        flip_idx = 4'($urandom_range(0, 11));
        @(negedge clk);
        load = 1'b0;
        flip_valid = 1'b0;
        // Orders must be held internally, not followed from the inputs.
        edge_order = {$urandom, $urandom, $urandom};
        center_order = {$urandom, $urandom};
        for (int i = 0; i < NP; i++) begin
            m_pos[i] = i * N_EDGE / NP;
            m_dist[i] = 0;
        end
        for (int k = 0; k < N_CENTER; k++) m_rev[k] = 1'b0;
        m_cur = 0;
        m_mode = 1;
        chk("load.err", flip_err, 1'b0);
        chk("load.rv", result_valid, 1'b0);
        check_state("load");
    endtask

    task automatic do_flip(input int idx);
        int tgt, step;
        bit legal, match, all;
        @(negedge clk);
        flip_valid = 1'b1;
        flip_idx = 4'(idx);
        @(negedge clk);
        flip_valid = 1'b0;
        flip_idx = 4'($urandom);
        legal = (idx < N_CENTER) && (m_mode == 1) && !m_rev[idx < N_CENTER ? idx : 0];
        if (m_mode != 1) begin
            chk("ign.err", flip_err, 1'b0);
            chk("ign.rv", result_valid, 1'b0);
            check_state("ign");
        end else if (!legal) begin
            chk("bad.err", flip_err, 1'b1);
            chk("bad.rv", result_valid, 1'b0);
            check_state("bad");
        end else begin
            m_rev[idx] = 1'b1;
            tgt = (m_pos[m_cur] + 1) % N_EDGE;
            step = 1;
            for (int guard = 0; guard < NP; guard++) begin
                bit occ;
                occ = 1'b0;
                for (int p = 0; p < NP; p++)
                    if (p != m_cur && m_pos[p] == tgt) occ = 1'b1;
                if (occ) begin
                    tgt = (tgt + 1) % N_EDGE;
                    step++;
                end
            end
            match = (m_center[idx] % 16) == (m_edge[tgt] % 16);
            chk("res.rv", result_valid, 1'b1);
            chk("res.match", result_match, match);
            chk("res.err", flip_err, 1'b0);
            chk("res.ready", flip_ready, 1'b0);
            chk("res.rev", center_revealed, rev_vec());
            all = 1'b1;
            for (int k = 0; k < N_CENTER; k++) if (!m_rev[k]) all = 1'b0;
            if (match) begin
                m_pos[m_cur] = tgt;
                m_dist[m_cur] = (m_dist[m_cur] + step > 31) ? 31 : m_dist[m_cur] + step;
                if (m_dist[m_cur] >= N_EDGE) begin
                    m_mode = 2;
                    m_winner = m_cur;
                end else if (all) begin
                    for (int k = 0; k < N_CENTER; k++) m_rev[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < N_CENTER; k++) m_rev[k] = 1'b0;
                m_cur = (m_cur + 1) % NP;
            end
            @(negedge clk);
            chk("next.rv", result_valid, 1'b0);
            check_state("next");
        end
    endtask

    task automatic play(input int budget);
        int idx, cnt;
        int pool[$];
        cnt = 0;
        while (cnt < budget && m_mode != 2) begin
            pool.delete();
            for (int k = 0; k < N_CENTER; k++) if (!m_rev[k]) pool.push_back(k);
            if ($urandom_range(0, 7) == 0 || pool.size() == 0) idx = $urandom_range(0, 15);
            else idx = pool[$urandom_range(0, pool.size() - 1)];
            if ($urandom_range(0, 5) == 0) @(negedge clk);
            do_flip(idx);
            cnt++;
        end
        if (m_mode == 2) begin
            do_flip($urandom_range(0, 11));
            do_flip($urandom_range(0, 15));
        end
    endtask

    task automatic rand_orders();
        int r;
        r = $urandom_range(1, 4);
        for (int k = 0; k < N_EDGE; k++) m_edge[k] = $urandom_range(0, r - 1);
        for (int k = 0; k < N_CENTER; k++) m_center[k] = $urandom_range(0, r - 1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; flip_valid = 1'b0; flip_idx = '0;
        edge_order = '0; center_order = '0;
        for (int i = 0; i < NP; i++) begin m_pos[i] = 0; m_dist[i] = 0; end
        for (int k = 0; k < N_CENTER; k++) m_rev[k] = 1'b0;
        m_cur = 0; m_mode = 0; m_winner = 0;
        repeat (2) @(negedge clk);
        chk("rst.err", flip_err, 1'b0);
        chk("rst.rv", result_valid, 1'b0);
        chk("rst.match", result_match, 1'b0);
        chk("rst.winner", winner, 2'd0);
        check_state("rst");
        rst = 1'b0;
        do_flip(3);

        for (int k = 0; k < N_EDGE; k++) m_edge[k] = k % 12;
        for (int k = 0; k < N_CENTER; k++) m_center[k] = k;
        do_load(1'b0);
        do_flip(1);
        do_flip(1);
        do_flip(5);
        play(300);

        for (int g = 0; g < 6; g++) begin
            rand_orders();
            do_load(g == 2);
            play(600);
        end
        rand_orders();
        do_load(1'b0);
        play(5);
        do_load(1'b1);
        play(600);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/chicken_board.md
Name: chicken_board

Overview:
- Game-board engine for the chicken race game; sits directly downstream of the tile-order randomiser.
- Captures one 24-tile edge order and one 12-tile center order, then runs turns: tile flips, match checks, chicken movement around the edge ring with wrap, turn hand-over and win detection.
- Feeds display and scoring logic.

Parameters:
- N_EDGE, 24: number of edge tiles on the ring.
- N_CENTER, 12: number of center tiles.
- TILE_W, 4: bits per tile code.
- N_PLAYERS, 2: number of chickens; legal range 2..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse; capture the orders and start a new game.
- edge_order  in  N_EDGE*TILE_W  edge tile codes; tile k is at bits [4k+3:4k].
- center_order  in  N_CENTER*TILE_W  center tile codes, same packing.
- flip_valid  in  1  flip request from the player input logic.
- flip_idx  in  4  center tile to flip.
- flip_ready  out  1  high only in TURN.
- flip_err  out  1  one-cycle pulse when a handshaked flip is illegal.
- cur_player  out  2  player whose turn it is.
- player_pos  out  N_PLAYERS*5  edge position per player; player i is at [5i+4:5i].
- center_revealed  out  N_CENTER  1 = tile currently face-up.
- result_valid  out  1  one-cycle pulse carrying the outcome of a flip.
- result_match  out  1  valid with result_valid; 1 = chicken moved.
- winner_valid  out  1  held high in WIN.
- winner  out  2  winning player; valid while winner_valid is high.

Behaviour:
- Reset: every output and register is 0; state is IDLE.
- States: IDLE, TURN, RESULT, WIN.
- load, any state (rst has priority):
  - Next cycle: orders registered; pos[i] = i*N_EDGE/N_PLAYERS; dist[i] = 0; center_revealed = 0; cur_player = 0; state = TURN.
  - A flip in the same cycle as load is dropped.
  - The input orders are sampled only on load.
- IDLE: flip_ready = 0; wait for load.
- TURN: flip_ready = 1. On flip_valid & flip_ready (cycle T):
  - Illegal flip (flip_idx >= N_CENTER, or the tile is already revealed): flip_err pulses at T+1; state stays TURN; nothing else changes.
  - Legal flip: set center_revealed[flip_idx]; go to RESULT at T+1.
- Target position: tgt = (pos[cur]+1) mod N_EDGE.
  - If another chicken occupies tgt, tgt advances by one more (mod N_EDGE).
  - Repeat until the position is free; at most N_PLAYERS-1 skips.
  - step = number of positions advanced.
- RESULT (T+1): result_valid = 1; result_match = (center code == edge[tgt]).
  - Match:
    - pos[cur] = tgt; dist[cur] += step, saturating at 31.
    - If dist[cur] >= N_EDGE: winner = cur; go to WIN.
    - Otherwise, if every center tile is now revealed, clear center_revealed; cur_player is unchanged; go to TURN at T+2.
  - Miss: clear center_revealed; cur_player = (cur+1) mod N_PLAYERS; go to TURN at T+2.
- Latency: handshake to result is 1 cycle; the next flip_ready is at T+2.
- WIN: winner_valid = 1 and flip_ready = 0; flips are ignored with no flip_err. Only load or rst leaves WIN.
- Position wrap: 23 -> 0 is a single step.
- Width rules:
  - Positions are stored mod N_EDGE.
  - dist is 5 bits.
  - Compare only TILE_W bits.
- All outputs are registered; there are no combinational paths from the inputs to the outputs.

Decomposition:
- Shared package:
  - N_EDGE, N_CENTER and TILE_W constants, shared with the order randomiser.
  - State encoding.
  - Player-index width.
- Sub-module ring_target:
  - Combinational.
  - Inputs: current position, occupancy vector.
  - Outputs: tgt and step.
  - Unit-testable on its own.
- Everything else stays in chicken_board.

Test Plan:
1. Assert rst for 2 cycles -> all outputs 0, flip_ready = 0. A flip_valid in IDLE is ignored.
2. Load an identity edge order (edge[k] = k mod 12) and an identity center order (center[k] = k), N_PLAYERS = 2 -> next cycle player_pos = {12, 0}, cur_player = 0, flip_ready = 1.
3. Flip idx 1 -> result_valid with match = 1; p0 pos = 1, dist = 1; center_revealed = 0x002; cur_player = 0.
   - Flip idx 1 again -> flip_err pulses; no state change.
4. From step 3, flip idx 5 (edge[2] = 2) -> match = 0; center_revealed = 0; cur_player = 1; p1 pos stays 12.
5. Skip: set p0 = 11 and p1 = 12 via match sequences; p0 flips idx 1 (edge[13] = 1) -> p0 pos = 13, dist increases by 2.
   - Wrap: a chicken at 23 matches edge[0] -> pos = 0.
6. Drive p0 matches until dist >= 24 -> winner_valid = 1, winner = 0; further flips produce no response.
   - load -> new game and winner_valid = 0.
   - Also assert load in the same cycle as flip_valid -> the flip is dropped.
